umi_decode_pipe: RTL and testbench

- Registered, flow-controlled successor to the combinational UMI command decoder.
- Accepts UMI packets on a valid/ready input, classifies each command into a one-hot class vector and a one-hot atomic-op vector, flags illegal encodings, and forwards the packet with one cycle of latency at full throughput through a 2-entry skid buffer.
- Optionally drops invalid packets and keeps saturating traffic statistics.
- Sits between a UMI port and endpoint/crossbar logic that needs pre-decoded commands.

---
 rtl/umi_decode_pkg.sv | 107 ++++++++++
 rtl/umi_skid_buf.sv | 74 +++++++
 rtl/umi_decode_pipe.sv | 115 +++++++++++
 tb/tb_umi_decode_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/umi_decode_pkg.sv
// ----------------------------------------------------------------------------
// umi_decode_pkg: UMI opcode/atomic constants, class indices, decode function.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package umi_decode_pkg;

  localparam int NCLASS  = 17;
  localparam int NATOMIC = 9;

  // Full-byte opcodes
  localparam logic [7:0] OP_INVALID   = 8'h00;
  localparam logic [7:0] OP_LINK      = 8'h0F;
  localparam logic [7:0] OP_ERROR     = 8'h1F;
  localparam logic [7:0] OP_RESP_LINK = 8'h0E;

  // Low-nibble opcodes
  localparam logic [3:0] OP_READ          = 4'h1;
  localparam logic [3:0] OP_WRITE         = 4'h3;
  localparam logic [3:0] OP_POSTED        = 4'h5;
  localparam logic [3:0] OP_RDMA          = 4'h7;
  localparam logic [3:0] OP_ATOMIC        = 4'h9;
  localparam logic [3:0] OP_USER0         = 4'hB;
  localparam logic [3:0] OP_FUTURE0       = 4'hD;
  localparam logic [3:0] OP_RESP_READ     = 4'h2;
  localparam logic [3:0] OP_RESP_WRITE    = 4'h4;
  localparam logic [3:0] OP_RESP_USER0    = 4'h6;
  localparam logic [3:0] OP_RESP_USER1    = 4'h8;
  localparam logic [3:0] OP_RESP_FUTURE0  = 4'hA;
  localparam logic [3:0] OP_RESP_FUTURE1  = 4'hC;

  typedef enum logic [7:0] {
    AT_ADD  = 8'h00,
    AT_AND  = 8'h01,
    AT_OR   = 8'h02,
    AT_XOR  = 8'h03,
    AT_MAX  = 8'h04,
    AT_MIN  = 8'h05,
    AT_MAXU = 8'h06,
    AT_MINU = 8'h07,
    AT_SWAP = 8'h08
  } atomic_e;

  // Class bit positions; requests occupy READ..ERROR, responses RESP_READ..RESP_LINK
  localparam int C_INVALID       = 0;
  localparam int C_READ          = 1;
  localparam int C_WRITE         = 2;
  localparam int C_POSTED        = 3;
  localparam int C_RDMA          = 4;
  localparam int C_ATOMIC        = 5;
  localparam int C_USER0         = 6;
  localparam int C_FUTURE0       = 7;
  localparam int C_LINK          = 8;
  localparam int C_ERROR         = 9;
  localparam int C_RESP_READ     = 10;
  localparam int C_RESP_WRITE    = 11;
  localparam int C_RESP_USER0    = 12;
  localparam int C_RESP_USER1    = 13;
  localparam int C_RESP_FUTURE0  = 14;
  localparam int C_RESP_FUTURE1  = 15;
  localparam int C_RESP_LINK     = 16;

  typedef struct packed {
    logic [NCLASS-1:0]  cls;
    logic [NATOMIC-1:0] atomic;
    logic               illegal;
  } decode_t;

  function automatic decode_t umi_decode(input logic [15:0] cmd);
    decode_t d;
    d = '0;
    case (cmd[7:0])
      OP_INVALID:   d.cls[C_INVALID]   = 1'b1;
      OP_LINK:      d.cls[C_LINK]      = 1'b1;
      OP_ERROR:     d.cls[C_ERROR]     = 1'b1;
      OP_RESP_LINK: d.cls[C_RESP_LINK] = 1'b1;
      default: begin
        case (cmd[3:0])
          OP_READ:         d.cls[C_READ]         = 1'b1;
          OP_WRITE:        d.cls[C_WRITE]        = 1'b1;
          OP_POSTED:       d.cls[C_POSTED]       = 1'b1;
          OP_RDMA:         d.cls[C_RDMA]         = 1'b1;
          OP_ATOMIC:       d.cls[C_ATOMIC]       = 1'b1;
          OP_USER0:        d.cls[C_USER0]        = 1'b1;
          OP_FUTURE0:      d.cls[C_FUTURE0]      = 1'b1;
          OP_RESP_READ:    d.cls[C_RESP_READ]    = 1'b1;
          OP_RESP_WRITE:   d.cls[C_RESP_WRITE]   = 1'b1;
          OP_RESP_USER0:   d.cls[C_RESP_USER0]   = 1'b1;
          OP_RESP_USER1:   d.cls[C_RESP_USER1]   = 1'b1;
          OP_RESP_FUTURE0: d.cls[C_RESP_FUTURE0] = 1'b1;
          OP_RESP_FUTURE1: d.cls[C_RESP_FUTURE1] = 1'b1;
          default:         d.illegal             = 1'b1;
        endcase
      end
    endcase
    // Unknown atomic types keep the ATOMIC class but carry no op bit
    if (d.cls[C_ATOMIC]) begin
      if (cmd[15:8] <= AT_SWAP) d.atomic = 9'd1 << cmd[15:8];
      else                      d.illegal = 1'b1;
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/umi_skid_buf.sv
// ----------------------------------------------------------------------------
// umi_skid_buf: 2-entry valid/ready skid buffer with registered ready.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module umi_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             push;
  logic             load;

  assign push = valid_i & ready_q;
  assign load = ~out_valid_q | ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (load) begin
      // ready_q is low whenever the skid is full, so no push competes here
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) out_data_d = data_i;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ~skid_valid_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = out_valid_q;
  assign data_o  = out_data_q;

endmodule

`default_nettype wire

// File: rtl/umi_decode_pipe.sv
// ----------------------------------------------------------------------------
// umi_decode_pipe: registered UMI command decoder behind a 2-entry skid buffer.
// Rev 1.0 -- define UMI_DECODE_STATS_EN to build the traffic counters.
// ----------------------------------------------------------------------------
`default_nettype none

module umi_decode_pipe
  import umi_decode_pkg::*;
#(
  parameter int CW           = 32,
  parameter int AW           = 64,
  parameter int DW           = 256,
  parameter int DROP_INVALID = 0,
  parameter int CNTW         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_cmd,
  input  logic [AW-1:0]     in_dstaddr,
  input  logic [AW-1:0]     in_srcaddr,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_cmd,
  output logic [AW-1:0]     out_dstaddr,
  output logic [AW-1:0]     out_srcaddr,
  output logic [DW-1:0]     out_data,
  output logic [16:0]       out_class,
  output logic [8:0]        out_atomic,
  output logic              out_illegal,
  input  logic              stats_clear,
  output logic [CNTW-1:0]   cnt_req,
  output logic [CNTW-1:0]   cnt_resp,
  output logic [CNTW-1:0]   cnt_invalid,
  output logic [CNTW-1:0]   cnt_illegal
);

  localparam int DECW = $bits(decode_t);
  localparam int PW   = CW + 2*AW + DW + DECW;

  decode_t       dec_in;
  decode_t       dec_out;
  logic          drop;
  logic [PW-1:0] pay_in;
  logic [PW-1:0] pay_out;

  assign dec_in = umi_decode(in_cmd[15:0]);
  // Dropped packets still handshake on the input but never enter the buffer
  assign drop   = (DROP_INVALID != 0) & dec_in.cls[C_INVALID];
  assign pay_in = {in_cmd, in_dstaddr, in_srcaddr, in_data, dec_in};

  umi_skid_buf #(
    .WIDTH (PW)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .valid_i (in_valid & ~drop),
    .ready_o (in_ready),
    .data_i  (pay_in),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (pay_out)
  );

  assign {out_cmd, out_dstaddr, out_srcaddr, out_data, dec_out} = pay_out;
  assign out_class   = dec_out.cls;
  assign out_atomic  = dec_out.atomic;
  assign out_illegal = dec_out.illegal;

`ifdef UMI_DECODE_STATS_EN
  logic [CNTW-1:0] cnt_req_q, cnt_resp_q, cnt_invalid_q, cnt_illegal_q;
  logic            accept;
  logic            is_req;
  logic            is_resp;

  assign accept  = in_valid & in_ready;
  assign is_req  = |dec_in.cls[C_ERROR:C_READ];
  assign is_resp = |dec_in.cls[C_RESP_LINK:C_RESP_READ];

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v, input logic en);
    return (en && (v != {CNTW{1'b1}})) ? v + CNTW'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      cnt_req_q     <= '0;
      cnt_resp_q    <= '0;
      cnt_invalid_q <= '0;
      cnt_illegal_q <= '0;
    end else begin
      cnt_req_q     <= sat_inc(cnt_req_q,     accept & is_req);
      cnt_resp_q    <= sat_inc(cnt_resp_q,    accept & is_resp);
      cnt_invalid_q <= sat_inc(cnt_invalid_q, accept & dec_in.cls[C_INVALID]);
      cnt_illegal_q <= sat_inc(cnt_illegal_q, accept & dec_in.illegal);
    end
  end

  assign cnt_req     = cnt_req_q;
  assign cnt_resp    = cnt_resp_q;
  assign cnt_invalid = cnt_invalid_q;
  assign cnt_illegal = cnt_illegal_q;
`else
  logic unused_stats;
  assign unused_stats = stats_clear;
  assign cnt_req      = '0;
  assign cnt_resp     = '0;
  assign cnt_invalid  = '0;
  assign cnt_illegal  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_umi_decode_pipe.sv
// ----------------------------------------------------------------------------
// tb_umi_decode_pipe: decode table, skid corner cases, drop/stats, random model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_umi_decode_pipe;

`ifdef UMI_DECODE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk, reset;
  logic         in_valid, in_ready, out_valid, out_ready, stats_clear, out_illegal;
  logic [31:0]  in_cmd, out_cmd;
  logic [63:0]  in_dstaddr, in_srcaddr, out_dstaddr, out_srcaddr;
  logic [255:0] in_data, out_data;
  logic [16:0]  out_class;
  logic [8:0]   out_atomic;
  logic [15:0]  cnt_req, cnt_resp, cnt_invalid, cnt_illegal;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stats_clear, b_unused_ill;
  logic [31:0]  b_in_cmd, b_out_cmd;
  logic [63:0]  b_unused_dst, b_unused_src;
  logic [255:0] b_unused_data;
  logic [16:0]  b_out_class;
  logic [8:0]   b_unused_atm;
  logic [3:0]   b_cnt_req, b_cnt_resp, b_cnt_invalid, b_cnt_illegal;

  umi_decode_pipe u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_dstaddr(in_dstaddr), .in_srcaddr(in_srcaddr), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
    .out_dstaddr(out_dstaddr), .out_srcaddr(out_srcaddr), .out_data(out_data),
    .out_class(out_class), .out_atomic(out_atomic), .out_illegal(out_illegal),
    .stats_clear(stats_clear), .cnt_req(cnt_req), .cnt_resp(cnt_resp),
    .cnt_invalid(cnt_invalid), .cnt_illegal(cnt_illegal)
  );

  umi_decode_pipe #(.DROP_INVALID(1), .CNTW(4)) u_drop (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_cmd(b_in_cmd),
    .in_dstaddr(64'h0), .in_srcaddr(64'h0), .in_data(256'h0),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_cmd(b_out_cmd),
    .out_dstaddr(b_unused_dst), .out_srcaddr(b_unused_src), .out_data(b_unused_data),
    .out_class(b_out_class), .out_atomic(b_unused_atm), .out_illegal(b_unused_ill),
    .stats_clear(b_stats_clear), .cnt_req(b_cnt_req), .cnt_resp(b_cnt_resp),
    .cnt_invalid(b_cnt_invalid), .cnt_illegal(b_cnt_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cmd;
    logic [16:0] cls;
    logic [8:0]  atm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0]  cmd;
    logic [63:0]  dst;
    logic [63:0]  src;
    logic [255:0] data;
  } pkt_t;

  vec_t       vt[$];
  pkt_t       mq[$];
  bit         mrdy;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] ops [21] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                           8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
                           8'h10, 8'h1E, 8'h1F, 8'h2F, 8'hE0};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [31:0] cmd, input int ci, input int ai, input logic ill);
    vec_t v;
    v.cmd = cmd; v.cls = '0; v.atm = '0; v.ill = ill;
    if (ci >= 0) v.cls[ci] = 1'b1;
    if (ai >= 0) v.atm[ai] = 1'b1;
    vt.push_back(v);
  endtask

  // Class numbering: odd nibbles are requests 1..7, even nibbles responses 10..15
  function automatic void ref_decode(input logic [31:0] cmd, output logic [16:0] cls,
                                     output logic [8:0] atm, output logic ill);
    int op, nib, typ, idx;
    op = int'(cmd[7:0]); nib = op % 16; typ = int'(cmd[15:8]);
    cls = '0; atm = '0; ill = 1'b0; idx = -1;
    if (op == 0) idx = 0;
    else if (op == 8'h0F) idx = 8;
    else if (op == 8'h1F) idx = 9;
    else if (op == 8'h0E) idx = 16;
    else if (nib >= 1 && nib <= 13) idx = (nib % 2 == 1) ? (nib + 1) / 2 : 9 + nib / 2;
    if (idx < 0) ill = 1'b1;
    else cls[idx] = 1'b1;
    if (idx == 5) begin
      if (typ <= 8) atm[typ] = 1'b1;
      else ill = 1'b1;
    end
  endfunction

  function automatic pkt_t rnd_pkt();
    pkt_t p;
    p.cmd  = {16'($urandom), 8'($urandom_range(0, 11)), ops[$urandom_range(0, 20)]};
    p.dst  = {$urandom, $urandom};
    p.src  = {$urandom, $urandom};
    p.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return p;
  endfunction

  function automatic logic [255:0] ev(input int v);
    return STATS ? 256'(v) : 256'(0);
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_cmd = '0; in_dstaddr = '0; in_srcaddr = '0;
    in_data = '0; out_ready = 1'b0; stats_clear = 1'b0;
    b_in_valid = 1'b0; b_in_cmd = '0; b_out_ready = 1'b0; b_stats_clear = 1'b0;

    add(32'h0001, 1, -1, 0);  add(32'h0003, 2, -1, 0);  add(32'h0309, 5, 3, 0);
    add(32'h0002, 10, -1, 0); add(32'h0005, 3, -1, 0);  add(32'h0007, 4, -1, 0);
    add(32'h000B, 6, -1, 0);  add(32'h000D, 7, -1, 0);  add(32'h000F, 8, -1, 0);
    add(32'h001F, 9, -1, 0);  add(32'h0004, 11, -1, 0); add(32'h0006, 12, -1, 0);
    add(32'h0008, 13, -1, 0); add(32'h000A, 14, -1, 0); add(32'h000C, 15, -1, 0);
    add(32'h000E, 16, -1, 0); add(32'h0000, 0, -1, 0);  add(32'h0C09, 5, -1, 1);
    add(32'h0809, 5, 8, 0);   add(32'h0009, 5, 0, 0);   add(32'h002F, -1, -1, 1);
    add(32'h001E, -1, -1, 1); add(32'h0010, -1, -1, 1); add(32'hAB05, 3, -1, 0);

    repeat (3) tick();
    chk("rst.in_ready", 256'(in_ready), 256'(0));
    chk("rst.out_valid", 256'(out_valid), 256'(0));
    chk("rst.out_class", 256'(out_class), 256'(0));
    chk("rst.out_data", out_data, 256'(0));
    chk("rst.cnt_req", 256'(cnt_req), 256'(0));
    reset = 1'b0;
    tick();
    chk("rel.in_ready", 256'(in_ready), 256'(1));

    // Back-to-back decode table at full throughput
    out_ready = 1'b1;
    foreach (vt[i]) begin
      in_valid = 1'b1; in_cmd = vt[i].cmd; in_data = {8{32'(i)}};
      in_dstaddr = {32'hD000_0000, 32'(i)};
      tick();
      chk("tbl.in_ready", 256'(in_ready), 256'(1));
      chk("tbl.out_valid", 256'(out_valid), 256'(1));
      chk("tbl.out_cmd", 256'(out_cmd), 256'(vt[i].cmd));
      chk("tbl.out_class", 256'(out_class), 256'(vt[i].cls));
      chk("tbl.out_atomic", 256'(out_atomic), 256'(vt[i].atm));
      chk("tbl.out_illegal", 256'(out_illegal), 256'(vt[i].ill));
      chk("tbl.out_data", out_data, {8{32'(i)}});
      chk("tbl.out_dst", 256'(out_dstaddr), 256'({32'hD000_0000, 32'(i)}));
    end
    in_valid = 1'b0;
    tick();
    chk("tbl.drain", 256'(out_valid), 256'(0));

    // Stall with three offered packets: skid fills, ready drops, FIFO order on release
    out_ready = 1'b0; in_valid = 1'b1; in_cmd = 32'h0005;
    tick();
    chk("stall.cls0", 256'(out_class), 256'(17'h1 << 3));
    chk("stall.rdy0", 256'(in_ready), 256'(1));
    in_cmd = 32'h0007;
    tick();
    chk("stall.rdy1", 256'(in_ready), 256'(0));
    chk("stall.hold1", 256'(out_class), 256'(17'h1 << 3));
    in_cmd = 32'h000B;
    tick();
    chk("stall.rdy2", 256'(in_ready), 256'(0));
    chk("stall.hold2", 256'(out_cmd), 256'(32'h0005));
    chk("stall.valid2", 256'(out_valid), 256'(1));
    out_ready = 1'b1;
    tick();
    chk("stall.rdma", 256'(out_class), 256'(17'h1 << 4));
    chk("stall.rdy3", 256'(in_ready), 256'(1));
    tick();
    chk("stall.user0", 256'(out_class), 256'(17'h1 << 6));
    in_valid = 1'b0;
    tick();
    chk("stall.empty", 256'(out_valid), 256'(0));

    // Drop of INVALID packets and the statistics counters
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_cmd = 32'h0001;
    tick();
    chk("drop.read", 256'(b_out_class), 256'(17'h1 << 1));
    b_in_cmd = 32'h0000;
    tick();
    chk("drop.gap", 256'(b_out_valid), 256'(0));
    chk("drop.rdy", 256'(b_in_ready), 256'(1));
    b_in_cmd = 32'h0004;
    tick();
    chk("drop.valid", 256'(b_out_valid), 256'(1));
    chk("drop.resp", 256'(b_out_class), 256'(17'h1 << 11));
    chk("drop.cmd", 256'(b_out_cmd), 256'(32'h0004));
    b_in_valid = 1'b0;
    tick();
    chk("drop.end", 256'(b_out_valid), 256'(0));
    chk("cnt.invalid", 256'(b_cnt_invalid), ev(1));
    chk("cnt.req1", 256'(b_cnt_req), ev(1));
    chk("cnt.resp1", 256'(b_cnt_resp), ev(1));
    b_in_valid = 1'b1; b_in_cmd = 32'h002F;
    tick();
    b_in_cmd = 32'h0C09;
    tick();
    chk("cnt.illegal", 256'(b_cnt_illegal), ev(2));
    chk("cnt.req2", 256'(b_cnt_req), ev(2));
    b_in_cmd = 32'h0001;
    repeat (5) tick();
    chk("cnt.req7", 256'(b_cnt_req), ev(7));
    repeat (15) tick();
    chk("cnt.sat", 256'(b_cnt_req), ev(15));
    b_stats_clear = 1'b1;
    tick();
    b_stats_clear = 1'b0;
    chk("clr.req", 256'(b_cnt_req), ev(0));
    chk("clr.resp", 256'(b_cnt_resp), ev(0));
    chk("clr.invalid", 256'(b_cnt_invalid), ev(0));
    chk("clr.illegal", 256'(b_cnt_illegal), ev(0));
    tick();
    chk("clr.inc", 256'(b_cnt_req), ev(1));
    b_in_valid = 1'b0;
    tick();

    // Random traffic against a queue model, with a reset in the middle
    reset = 1'b1;
    tick();
    mq.delete(); mrdy = 1'b0;
    for (int c = 0; c < 600; c++) begin
      pkt_t p;
      bit hs_in, hs_out, do_rst;
      logic [16:0] ecls;
      logic [8:0] eatm;
      logic eill;
      do_rst = (c >= 300 && c < 302);
      reset = do_rst;
      p = rnd_pkt();
      in_valid = ($urandom_range(0, 9) < 7);
      in_cmd = p.cmd; in_dstaddr = p.dst; in_srcaddr = p.src; in_data = p.data;
      out_ready = ($urandom_range(0, 9) < 6);
      hs_in  = in_valid && mrdy && (mq.size() < 2);
      hs_out = (mq.size() > 0) && out_ready;
      tick();
      if (do_rst) begin
        mq.delete(); mrdy = 1'b0;
      end else begin
        if (hs_out) void'(mq.pop_front());
        if (hs_in) mq.push_back(p);
        mrdy = 1'b1;
      end
      chk("rnd.in_ready", 256'(in_ready), 256'(mrdy && (mq.size() < 2)));
      chk("rnd.out_valid", 256'(out_valid), 256'(mq.size() > 0));
      if (mq.size() > 0) begin
        ref_decode(mq[0].cmd, ecls, eatm, eill);
        chk("rnd.cmd", 256'(out_cmd), 256'(mq[0].cmd));
        chk("rnd.dst", 256'(out_dstaddr), 256'(mq[0].dst));
        chk("rnd.src", 256'(out_srcaddr), 256'(mq[0].src));
        chk("rnd.data", out_data, mq[0].data);
        chk("rnd.class", 256'(out_class), 256'(ecls));
        chk("rnd.atomic", 256'(out_atomic), 256'(eatm));
        chk("rnd.illegal", 256'(out_illegal), 256'(eill));
      end
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
